// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of an async FIFO, living in the RCLK domain.
// Pops WIDTH-bit entries and packs LANES consecutive entries into one wide word,
// lane 0 in the low bits. Each word is offered on a valid/ready output. FLUSH emits
// a partially filled word with its valid-lane count.
//
// Ports:
//   RCLK       read-domain clock, posedge
//   RRST       asynchronous active-high reset
//   REMPTY     FIFO empty flag
//   RDATA      FIFO head entry, valid while REMPTY=0
//   RINC       FIFO pop strobe (combinational)
//   FLUSH      request to emit the current partial word
//   OUT_DATA   packed output word
//   OUT_COUNT  number of valid lanes in OUT_DATA
//   OUT_VALID  output word valid
//   OUT_READY  downstream accepts on OUT_VALID & OUT_READY
module fifo_rd_packer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                         RCLK,
  input  logic                         RRST,
  input  logic                         REMPTY,
  input  logic [WIDTH-1:0]             RDATA,
  output logic                         RINC,
  input  logic                         FLUSH,
  output logic [WIDTH*LANES-1:0]       OUT_DATA,
  output logic [$clog2(LANES+1)-1:0]   OUT_COUNT,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);

  localparam int unsigned IdxW = $clog2(LANES);
  localparam int unsigned CntW = $clog2(LANES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  logic [LANES-1:0][WIDTH-1:0] acc_q, acc_d, acc_wr;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        fp_q, fp_d;
  logic [WIDTH*LANES-1:0]      out_data_q, out_data_d;
  logic [CntW-1:0]             out_count_q, out_count_d;
  logic                        out_valid_q, out_valid_d;

  logic out_free;
  logic last_lane;
  logic pop;

  // The output register can take a new word this edge if it is empty or draining.
  assign out_free  = ~out_valid_q | OUT_READY;
  assign last_lane = (idx_q == LastIdx);

  // Only the last lane needs a free output register; earlier lanes land in ACC.
  // RRST gating keeps the strobe low for the whole reset interval.
  assign pop  = ~RRST & ~REMPTY & ~fp_q & ~(last_lane & ~out_free);
  assign RINC = pop;

  always_comb begin
    // Accumulator with the current FIFO head dropped into lane IDX.
    acc_wr        = acc_q;
    acc_wr[idx_q] = RDATA;

    acc_d       = acc_q;
    idx_d       = idx_q;
    fp_d        = fp_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    if (fp_q) begin
      // Pops are blocked while a flush is pending, so IDX is nonzero here.
      if (out_free) begin
        out_data_d  = acc_q;
        out_count_d = CntW'(idx_q);
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
        fp_d        = 1'b0;
      end
    end else if (pop) begin
      if (last_lane) begin
        // Completing byte wins over a coincident FLUSH: a normal full word.
        out_data_d  = acc_wr;
        out_count_d = CntW'(LANES);
        out_valid_d = 1'b1;
        acc_d       = '0;
        idx_d       = '0;
      end else begin
        acc_d = acc_wr;
        idx_d = idx_q + 1'b1;
        fp_d  = FLUSH;
      end
    end else if (FLUSH && (idx_q != '0)) begin
      fp_d = 1'b1;
    end
  end

  always_ff @(posedge RCLK or posedge RRST) begin
    if (RRST) begin
      acc_q       <= '0;
      idx_q       <= '0;
      fp_q        <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      fp_q        <= fp_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_COUNT = out_count_q;
  assign OUT_VALID = out_valid_q;

endmodule
